// File: rtl/avalon_pio_pkg.sv
// Shared register map, STATUS bit positions and pulse FSM state type for avalon_pio_pulse_out.
package avalon_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_SET    = 3'd2;
    localparam logic [2:0] ADDR_CLR    = 3'd3;
    localparam logic [2:0] ADDR_PULSE  = 3'd4;
    localparam logic [2:0] ADDR_PLEN   = 3'd5;
    localparam logic [2:0] ADDR_OUT    = 3'd6;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/pio_pulse_timer.sv
// Load/decrement pulse timer: busy for exactly len cycles after start, done_pulse on the final cycle.
module pio_pulse_timer
    import avalon_pio_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    output logic               busy,
    output logic               done_pulse
);

    pulse_state_e       state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // start is only honoured from IDLE, so a running pulse can never be restarted
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        done_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PULSE;
                    count_d = len;
                end
            end
            PULSE: begin
                count_d = count_q - 1'b1;
                if (count_q == COUNT_W'(1)) begin
                    state_d    = IDLE;
                    done_pulse = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == PULSE);

endmodule

// File: rtl/avalon_pio_pulse_out.sv
// Avalon-MM output PIO with atomic set/clear and a hardware timed inversion pulse.
// Optional macro PIO_PULSE_IRQ_EN adds a sticky done flag driving the irq port.
module avalon_pio_pulse_out
    import avalon_pio_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
    parameter int               COUNT_W       = 16,
    parameter int               PULSE_DEFAULT = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
`ifdef PIO_PULSE_IRQ_EN
    ,
    output logic             irq
`endif
);

    logic [WIDTH-1:0]   data_out;
    logic [WIDTH-1:0]   pulse_mask;
    logic [COUNT_W-1:0] plen;
    logic               busy;
    logic               done_pulse;
    logic               done;
    logic               wr_en;
    logic               start;
    logic [WIDTH-1:0]   wd;

    assign wr_en = chipselect && !write_n;
    assign wd    = writedata[WIDTH-1:0];
    assign start = wr_en && (address == ADDR_PULSE) && (|wd) && (|plen) && !busy;

    wire unused_wd = &{1'b0, writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out   <= RESET_VALUE;
            plen       <= COUNT_W'(PULSE_DEFAULT);
            pulse_mask <= '0;
        end else begin
            if (wr_en) begin
                case (address)
                    ADDR_DATA: data_out <= wd;
                    ADDR_SET:  data_out <= data_out | wd;
                    ADDR_CLR:  data_out <= data_out & ~wd;
                    ADDR_PLEN: plen     <= writedata[COUNT_W-1:0];
                    default:   ;
                endcase
            end
            if (start)
                pulse_mask <= wd;
            else if (done_pulse)
                pulse_mask <= '0;
        end
    end

`ifdef PIO_PULSE_IRQ_EN
    // end-of-pulse takes priority over a coincident software clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            done <= 1'b0;
        else if (done_pulse)
            done <= 1'b1;
        else if (wr_en && (address == ADDR_STATUS) && writedata[STAT_DONE])
            done <= 1'b0;
    end

    assign irq = done;
`else
    assign done = 1'b0;
`endif

    pio_pulse_timer #(
        .COUNT_W(COUNT_W)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .len       (plen),
        .busy      (busy),
        .done_pulse(done_pulse)
    );

    assign out_port = data_out ^ (busy ? pulse_mask : '0);

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata = 32'(data_out);
            ADDR_STATUS: begin
                readdata[STAT_BUSY] = busy;
                readdata[STAT_DONE] = done;
            end
            ADDR_PLEN: readdata = 32'(plen);
            ADDR_OUT:  readdata = 32'(out_port);
            default:   readdata = '0;
        endcase
    end

endmodule
